// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial coprocessor for the MIPS32 system data bus.
// Software writes n and GO, then polls STATUS (or uses done as an interrupt) and reads RESULT.
module fact_accel #(
   parameter int DW   = 32,
   parameter int NW   = 4,
   parameter int NMAX = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [1:0]    addr,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] rd,
   output logic          busy,
   output logic          done
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [1:0]    A_N      = 2'd0;
   localparam logic [1:0]    A_CTRL   = 2'd1;
   localparam logic [1:0]    A_STATUS = 2'd2;
   localparam logic [1:0]    A_RESULT = 2'd3;
   localparam logic [NW-1:0] NMAX_N   = NW'(NMAX);

   state_t        state_reg, state_next;
   logic [NW-1:0] n_reg, n_next;
   logic [NW-1:0] count_reg, count_next;
   logic [DW-1:0] product_reg, product_next;
   logic [DW-1:0] result_reg, result_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;

   logic          wr_n, wr_go, wr_status;
   logic          wd_unused;

   assign wr_n      = we && (addr == A_N);
   assign wr_go     = we && (addr == A_CTRL) && wd[0];
   assign wr_status = we && (addr == A_STATUS);
   assign wd_unused = ^wd[DW-1:NW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         n_reg       <= '0;
         count_reg   <= '0;
         product_reg <= '0;
         result_reg  <= '0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         n_reg       <= n_next;
         count_reg   <= count_next;
         product_reg <= product_next;
         result_reg  <= result_next;
         done_reg    <= done_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      n_next       = n_reg;
      count_next   = count_reg;
      product_next = product_reg;
      result_next  = result_reg;
      done_next    = done_reg;
      err_next     = err_reg;

      // W1C clears come first so that a completion on the same edge overrides them
      if (wr_status) begin
         if (wd[0]) done_next = 1'b0;
         if (wd[2]) err_next  = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (wr_n) n_next = wd[NW-1:0];
            if (wr_go) begin
               done_next = 1'b0;
               err_next  = 1'b0;
               if (n_reg > NMAX_N) begin
                  err_next    = 1'b1;
                  done_next   = 1'b1;
                  result_next = '0;
               end else begin
                  product_next = DW'(1);
                  count_next   = n_reg;
                  state_next   = BUSY;
               end
            end
         end
         BUSY: begin
            if (count_reg <= NW'(1)) begin
               result_next = product_reg;
               done_next   = 1'b1;
               state_next  = IDLE;
            end else begin
               product_next = product_reg * {{(DW-NW){1'b0}}, count_reg};
               count_next   = count_reg - NW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rd = '0;
      case (addr)
         A_N:      rd = {{(DW-NW){1'b0}}, n_reg};
         A_CTRL:   rd = '0;
         A_STATUS: rd = {{(DW-3){1'b0}}, err_reg, (state_reg == BUSY), done_reg};
         A_RESULT: rd = result_reg;
         default:  rd = '0;
      endcase
   end

   assign busy = (state_reg == BUSY);
   assign done = done_reg;

endmodule

// File: tb/tb_fact_accel.sv
// Directed-vector bench for fact_accel: reset, runs, error path, busy-time writes,
// asynchronous reset and a back-to-back sweep of n=0..12.
module tb_fact_accel;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        busy;
   logic        done;

   int checks = 0;
   int passes = 0;

   fact_accel #(.DW(32), .NW(4), .NMAX(12)) dut (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .addr (addr),
      .wd   (wd),
      .rd   (rd),
      .busy (busy),
      .done (done)
   );

   always #10 clk = ~clk;

   function automatic logic [31:0] fact(input int n);
      logic [31:0] f;
      f = 32'd1;
      for (int i = 2; i <= n; i++) f = f * 32'(i);
      return f;
   endfunction

   // Called at a falling edge; the write lands on the next rising edge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      wd   = d;
      we   = 1'b1;
      @(negedge clk);
      we   = 1'b0;
      wd   = '0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rd;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst = 1'b1; we = 1'b0; addr = '0; wd = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_flags: busy=%b done=%b, required 0 0", busy, done);
      else passes++;
      for (int a = 0; a < 4; a++) begin
         read_reg(2'(a), v);
         checks++;
         if (v !== 32'd0) $display("FAIL reset_rd%0d: got %0h, required 0", a, v);
         else passes++;
      end
      rst = 1'b0;
      @(negedge clk);
      $display("reset: released");
   endtask

   task automatic test_runs();
      int          n_tab   [4] = '{5, 0, 1, 12};
      int          lat_tab [4] = '{5, 1, 1, 12};
      logic [31:0] res_tab [4] = '{32'd120, 32'd1, 32'd1, 32'h1C8CFC00};
      logic [31:0] v;
      int          cnt;
      for (int i = 0; i < 4; i++) begin
         bus_write(2'd0, 32'(n_tab[i]));
         bus_write(2'd1, 32'd1);
         count_busy(cnt);
         checks++;
         if (cnt !== lat_tab[i]) $display("FAIL run_latency n=%0d: got %0d, required %0d", n_tab[i], cnt, lat_tab[i]);
         else passes++;
         read_reg(2'd2, v);
         checks++;
         if (v !== 32'h1) $display("FAIL run_status n=%0d: got %0h, required 1", n_tab[i], v);
         else passes++;
         read_reg(2'd3, v);
         checks++;
         if (v !== res_tab[i]) $display("FAIL run_result n=%0d: got %0h, required %0h", n_tab[i], v, res_tab[i]);
         else passes++;
         $display("run: n=%0d busy_cycles=%0d result=%0d", n_tab[i], cnt, v);
         @(negedge clk);
      end
   endtask

   task automatic test_error();
      logic [31:0] v;
      bus_write(2'd0, 32'd13);
      bus_write(2'd1, 32'd1);
      read_reg(2'd2, v);
      checks++;
      if (v !== 32'h5) $display("FAIL err_status: got %0h, required 5", v);
      else passes++;
      read_reg(2'd3, v);
      checks++;
      if (v !== 32'd0) $display("FAIL err_result: got %0h, required 0", v);
      else passes++;
      @(negedge clk);
      bus_write(2'd2, 32'h5);
      read_reg(2'd2, v);
      checks++;
      if (v !== 32'd0) $display("FAIL err_clear: got %0h, required 0", v);
      else passes++;
      $display("error: n=13 flagged and cleared");
      @(negedge clk);
   endtask

   task automatic test_busy_writes();
      logic [31:0] v;
      int          cnt;
      bus_write(2'd0, 32'd6);
      bus_write(2'd1, 32'd1);
      repeat (2) @(negedge clk);
      bus_write(2'd0, 32'd9);
      bus_write(2'd1, 32'd1);
      count_busy(cnt);
      checks++;
      if (cnt !== 2) $display("FAIL busy_wr_latency: remaining cycles %0d, required 2", cnt);
      else passes++;
      read_reg(2'd2, v);
      checks++;
      if (v !== 32'h1) $display("FAIL busy_wr_status: got %0h, required 1", v);
      else passes++;
      read_reg(2'd3, v);
      checks++;
      if (v !== 32'd720) $display("FAIL busy_wr_result: got %0d, required 720", v);
      else passes++;
      read_reg(2'd0, v);
      checks++;
      if (v !== 32'd6) $display("FAIL busy_wr_n: got %0d, required 6", v);
      else passes++;
      $display("busy_writes: n=6 result=720 (N/GO during run ignored)");
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [31:0] v;
      int          cnt;
      bus_write(2'd0, 32'd10);
      bus_write(2'd1, 32'd1);
      repeat (3) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL arst_flags: busy=%b done=%b, required 0 0", busy, done);
      else passes++;
      for (int a = 0; a < 4; a += 1) begin
         if (a == 1) continue;
         read_reg(2'(a), v);
         checks++;
         if (v !== 32'd0) $display("FAIL arst_rd%0d: got %0h, required 0", a, v);
         else passes++;
      end
      rst = 1'b0;
      @(negedge clk);
      bus_write(2'd0, 32'd4);
      bus_write(2'd1, 32'd1);
      count_busy(cnt);
      checks++;
      if (cnt !== 4) $display("FAIL arst_rerun_latency: got %0d, required 4", cnt);
      else passes++;
      read_reg(2'd3, v);
      checks++;
      if (v !== 32'd24) $display("FAIL arst_rerun_result: got %0d, required 24", v);
      else passes++;
      $display("async_reset: mid-run reset, rerun n=4 result=%0d", v);
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      int          lat;
      for (int n = 0; n <= 12; n++) begin
         bus_write(2'd0, 32'(n));
         bus_write(2'd1, 32'd1);
         checks++;
         if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_start n=%0d: done=%b busy=%b, required 0 1", n, done, busy);
         else passes++;
         lat = (n < 1) ? 1 : n;
         repeat (lat - 1) @(negedge clk);
         bus_write(2'd2, 32'h1);
         checks++;
         if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL b2b_done n=%0d: done=%b busy=%b, required 1 0", n, done, busy);
         else passes++;
         read_reg(2'd3, v);
         checks++;
         if (v !== fact(n)) $display("FAIL b2b_result n=%0d: got %0h, required %0h", n, v, fact(n));
         else passes++;
         $display("b2b: n=%0d result=%0d", n, v);
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_runs();
      test_error();
      test_busy_writes();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
